sort_ctrl: RTL



---
 rtl/sort_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sort_ctrl.sv
// Huffman frequency-sort sequencer: loads NUM counts, sorts them in place, then streams them out.
// Define SORT_DESCEND_EN for descending output. The default build sorts ascending.

module sort_en_dff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         ena,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // NOTE: the register holds data only, so it has no reset. Control reset alone discards a batch.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so that every slot samples the pre-edge values of its neighbours.
      if (ena) q <= d;
   end
endmodule

module sort_ctrl #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM        = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy
);
   localparam int CW = $clog2(NUM);
   localparam logic [CW-1:0] LAST = CW'(NUM - 1);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]         pass_q, pass_d;
   logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
   logic [DATA_WIDTH-1:0] slot_q [NUM];
   logic [DATA_WIDTH-1:0] slot_d [NUM];
   logic                  ena [NUM];

   function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b);
`ifdef SORT_DESCEND_EN
      return a < b;
`else
      return a > b;
`endif
   endfunction

   for (genvar g = 0; g < NUM; g++) begin : g_slot
      sort_en_dff #(.W(DATA_WIDTH)) u_slot (
         .clk (clk),
         .ena (ena[g]),
         .d   (slot_d[g]),
         .q   (slot_q[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD;
         wr_cnt_q <= '0;
         pass_q   <= '0;
         rd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         pass_q   <= pass_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_comb begin
      // NOTE: each signal gets a default before the case statement, so no path can infer a latch.
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      pass_d   = pass_q;
      rd_cnt_d = rd_cnt_q;
      for (int i = 0; i < NUM; i++) begin
         ena[i]    = 1'b0;
         slot_d[i] = slot_q[i];
      end

      case (state_q)
         LOAD: begin
            if (in_valid) begin
               ena[wr_cnt_q]    = 1'b1;
               slot_d[wr_cnt_q] = in_data;
               if (wr_cnt_q == LAST) begin
                  state_d  = SORT;
                  wr_cnt_d = '0;
                  pass_d   = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         SORT: begin
            // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..
            for (int i = 0; i < NUM - 1; i++) begin
               if ((i % 2) == int'(pass_q[0]) && out_of_order(slot_q[i], slot_q[i+1])) begin
                  ena[i]      = 1'b1;
                  ena[i+1]    = 1'b1;
                  slot_d[i]   = slot_q[i+1];
                  slot_d[i+1] = slot_q[i];
               end
            end
            if (pass_q == LAST) begin
               state_d  = DRAIN;
               rd_cnt_d = '0;
            end else begin
               pass_d = pass_q + 1'b1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (rd_cnt_q == LAST) begin
                  state_d  = LOAD;
                  rd_cnt_d = '0;
               end else begin
                  rd_cnt_d = rd_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q != LOAD);
   assign out_last  = out_valid && (rd_cnt_q == LAST);
   assign out_data  = out_valid ? slot_q[rd_cnt_q] : '0;

endmodule
